// File: rtl/des_key_pkg.sv
// -----------------------------------------------------------------------------
// des_key_pkg
// Shared DES key-schedule definitions:
//   - KEY_W / HALF_W / SUBKEY_W : fixed DES widths (56 / 28 / 48)
//   - shift_t                   : 2-bit per-half left-rotate amount
//   - PC2_TABLE                 : standard DES PC-2 table, 1-based, bit 1 = MSB
//   - SHIFT_SCHEDULE            : per-round rotate amounts for round controllers
//   - pc2_map()                 : applies PC-2 to a 56-bit C||D state
// -----------------------------------------------------------------------------
package des_key_pkg;

    localparam int KEY_W    = 56;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;
    localparam int ROUNDS   = 16;

    typedef logic [1:0] shift_t;

    localparam shift_t SHIFT_0       = 2'd0;
    localparam shift_t SHIFT_1       = 2'd1;
    localparam shift_t SHIFT_2       = 2'd2;
    localparam shift_t SHIFT_ILLEGAL = 2'd3;

    // Entry i gives the 1-based source bit (1 = bit [55]) of subkey bit i+1
    // (subkey bit 1 = bit [47]).
    localparam int PC2_TABLE [SUBKEY_W] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam shift_t SHIFT_SCHEDULE [ROUNDS] = '{
        SHIFT_1, SHIFT_1, SHIFT_2, SHIFT_2, SHIFT_2, SHIFT_2, SHIFT_2, SHIFT_2,
        SHIFT_1, SHIFT_2, SHIFT_2, SHIFT_2, SHIFT_2, SHIFT_2, SHIFT_2, SHIFT_1
    };

    // PC-2 selection: converts the 1-based MSB-first table into vector indices.
    function automatic logic [SUBKEY_W-1:0] pc2_map(input logic [KEY_W-1:0] cd);
        logic [SUBKEY_W-1:0] sub;
        sub = {SUBKEY_W{1'b0}};
        for (int i = 0; i < SUBKEY_W; i++) begin
            sub[SUBKEY_W-1-i] = cd[KEY_W-PC2_TABLE[i]];
        end
        return sub;
    endfunction

endpackage

// File: rtl/key_half_rotate.sv
// -----------------------------------------------------------------------------
// key_half_rotate
// Combinational left rotate of one 28-bit key half by 0, 1 or 2 bits.
// The illegal amount 3 passes the half through unrotated.
// Ports:
//   half_in  in  28  C or D half
//   amount   in   2  rotate amount (shift_t)
//   half_out out 28  rotated half
// -----------------------------------------------------------------------------
module key_half_rotate
    import des_key_pkg::*;
(
    input  logic [HALF_W-1:0] half_in,
    input  shift_t            amount,
    output logic [HALF_W-1:0] half_out
);

    // Rotate selection; wraps within the half only.
    always_comb begin
        half_out = half_in;
        case (amount)
            SHIFT_0: half_out = half_in;
            SHIFT_1: half_out = {half_in[HALF_W-2:0], half_in[HALF_W-1]};
            SHIFT_2: half_out = {half_in[HALF_W-3:0], half_in[HALF_W-1:HALF_W-2]};
            default: half_out = half_in;
        endcase
    end

endmodule

// File: rtl/key_round_step.sv
// -----------------------------------------------------------------------------
// key_round_step
// One DES key-schedule round step: rotates the C and D halves of the 56-bit
// post-PC-1 key state left by 0/1/2 bits and registers the result (1 cycle).
// Optional feature macro: KEY_ROUND_STEP_PC2_EN adds a registered PC-2 subkey.
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   in_valid     in   1   in_key / shift_amount valid this cycle
//   in_key       in  56   key state, [55:28] = C, [27:0] = D
//   shift_amount in   2   rotate amount per half (3 is illegal)
//   out_valid    out  1   one-cycle pulse per accepted input
//   shifted_key  out 56   registered rotated state
//   shift_err    out  1   registered, set when the accepted amount was 3
//   round_key    out 48   registered PC-2 of rotated state (macro only)
// -----------------------------------------------------------------------------
module key_round_step
    import des_key_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [KEY_W-1:0]    in_key,
    input  logic [1:0]          shift_amount,
    output logic                out_valid,
    output logic [KEY_W-1:0]    shifted_key,
    output logic                shift_err
`ifdef KEY_ROUND_STEP_PC2_EN
    ,
    output logic [SUBKEY_W-1:0] round_key
`endif
);

    logic [HALF_W-1:0] c_rot_s;
    logic [HALF_W-1:0] d_rot_s;
    logic [KEY_W-1:0]  next_key_s;
    logic              illegal_s;

    key_half_rotate u_rot_c (
        .half_in  (in_key[KEY_W-1:HALF_W]),
        .amount   (shift_amount),
        .half_out (c_rot_s)
    );

    key_half_rotate u_rot_d (
        .half_in  (in_key[HALF_W-1:0]),
        .amount   (shift_amount),
        .half_out (d_rot_s)
    );

    // Join the rotated halves and flag the illegal amount.
    always_comb begin
        next_key_s = {c_rot_s, d_rot_s};
        illegal_s  = (shift_amount == SHIFT_ILLEGAL);
    end

    // Output registers: load on accepted input, otherwise hold with valid low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            shifted_key <= {KEY_W{1'b0}};
            shift_err   <= 1'b0;
        end else if (in_valid) begin
            out_valid   <= 1'b1;
            shifted_key <= next_key_s;
            shift_err   <= illegal_s;
        end else begin
            out_valid   <= 1'b0;
        end
    end

`ifdef KEY_ROUND_STEP_PC2_EN
    // Subkey register, loaded in step with shifted_key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_key <= {SUBKEY_W{1'b0}};
        end else if (in_valid) begin
            round_key <= pc2_map(next_key_s);
        end else begin
            round_key <= round_key;
        end
    end
`endif

endmodule

// File: tb/tb_key_round_step.sv
module tb_key_round_step;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [55:0] in_key;
    logic [1:0]  shift_amount;
    logic        out_valid;
    logic [55:0] shifted_key;
    logic        shift_err;
`ifdef KEY_ROUND_STEP_PC2_EN
    logic [47:0] round_key;
`endif

    int n_total;
    int n_pass;

    typedef struct packed {
        logic [55:0] key;
        logic        err;
    } exp_t;

    exp_t sb_q[$];

    key_round_step dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_key       (in_key),
        .shift_amount (shift_amount),
        .out_valid    (out_valid),
        .shifted_key  (shifted_key),
        .shift_err    (shift_err)
`ifdef KEY_ROUND_STEP_PC2_EN
        ,
        .round_key    (round_key)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] rot_half(input logic [27:0] h, input int n);
        logic [27:0] r;
        r = h;
        for (int i = 0; i < n; i++) r = {r[26:0], r[27]};
        return r;
    endfunction

    function automatic logic [55:0] model_shift(input logic [55:0] k, input logic [1:0] a);
        if (a == 2'd3) return k;
        return {rot_half(k[55:28], int'(a)), rot_half(k[27:0], int'(a))};
    endfunction

`ifdef KEY_ROUND_STEP_PC2_EN
    function automatic logic [47:0] model_pc2(input logic [55:0] k);
        int tbl [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                         41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
        logic [47:0] s;
        for (int i = 0; i < 48; i++) s[47-i] = k[56-tbl[i]];
        return s;
    endfunction
`endif

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_key = 56'h0; shift_amount = 2'd0;
        #3;
        n_total++;
        if (shifted_key !== 56'h0) $display("FAIL reset_key: got %h want %h", shifted_key, 56'h0);
        else n_pass++;
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (shift_err !== 1'b0) $display("FAIL reset_err: got %b want 0", shift_err);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Known vectors; expected values are literal constants pushed to the scoreboard.
    task automatic test_spec_vectors();
        logic [1:0]  amts [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        logic [55:0] exps [5] = '{56'hABCDEF12345678, 56'h579BDE3468ACF0,
                                  56'hAF37BC68D159E0, 56'hABCDEF12345678, 56'h579BDE3468ACF0};
        logic        errs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        exp_t e;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb_q.pop_front();
                n_total++;
                if (out_valid !== 1'b1 || shifted_key !== e.key || shift_err !== e.err)
                    $display("FAIL vector_%0d: got v=%b key=%h err=%b want v=1 key=%h err=%b",
                             i - 1, out_valid, shifted_key, shift_err, e.key, e.err);
                else n_pass++;
            end
            if (i < 5) begin
                in_valid = 1'b1; in_key = 56'hABCDEF12345678; shift_amount = amts[i];
                sb_q.push_back('{key: exps[i], err: errs[i]});
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    // Illegal input then idle: err and key must hold, valid must drop.
    task automatic test_hold();
        @(negedge clk);
        in_valid = 1'b1; in_key = 56'h13579BDF02468A; shift_amount = 2'd3;
        @(negedge clk);
        in_valid = 1'b0; in_key = 56'hFFFFFFFFFFFFFF; shift_amount = 2'd1;
        repeat (2) @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0 || shifted_key !== 56'h13579BDF02468A || shift_err !== 1'b1)
            $display("FAIL hold: got v=%b key=%h err=%b want v=0 key=%h err=1",
                     out_valid, shifted_key, shift_err, 56'h13579BDF02468A);
        else n_pass++;
    endtask

    // 16 rounds, each result fed back; model chain checked every round.
    task automatic test_streaming();
        int          sched [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
        logic [55:0] orig;
        logic [55:0] model;
        orig  = {$urandom(), $urandom()} ;
        model = orig;
        for (int r = 0; r <= 16; r++) begin
            @(negedge clk);
            if (r > 0) begin
                n_total++;
                if (out_valid !== 1'b1 || shifted_key !== model)
                    $display("FAIL stream_round_%0d: got v=%b key=%h want v=1 key=%h",
                             r, out_valid, shifted_key, model);
                else n_pass++;
            end
            if (r < 16) begin
                in_valid     = 1'b1;
                in_key       = (r == 0) ? orig : shifted_key;
                shift_amount = 2'(sched[r]);
                model        = model_shift(model, 2'(sched[r]));
            end else begin
                in_valid = 1'b0;
            end
        end
        n_total++;
        if (shifted_key !== orig) $display("FAIL stream_wrap: got %h want %h", shifted_key, orig);
        else n_pass++;
    endtask

    // Random back-to-back inputs, scoreboard model, no bubbles allowed.
    task automatic test_back_to_back();
        exp_t        e;
        logic [55:0] k;
        logic [1:0]  a;
        for (int i = 0; i <= 24; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = sb_q.pop_front();
                n_total++;
                if (out_valid !== 1'b1 || shifted_key !== e.key || shift_err !== e.err)
                    $display("FAIL b2b_%0d: got v=%b key=%h err=%b want v=1 key=%h err=%b",
                             i - 1, out_valid, shifted_key, shift_err, e.key, e.err);
                else n_pass++;
`ifdef KEY_ROUND_STEP_PC2_EN
                n_total++;
                if (round_key !== model_pc2(e.key))
                    $display("FAIL b2b_pc2_%0d: got %h want %h", i - 1, round_key, model_pc2(e.key));
                else n_pass++;
`endif
            end
            if (i < 24) begin
                k = {$urandom(), $urandom()};
                a = 2'($urandom_range(0, 3));
                in_valid = 1'b1; in_key = k; shift_amount = a;
                sb_q.push_back('{key: model_shift(k, a), err: (a == 2'd3)});
            end else begin
                in_valid = 1'b0;
            end
        end
    endtask

    // Reset asserted between edges while streaming must clear outputs at once.
    task automatic test_reset_midstream();
        @(negedge clk);
        in_valid = 1'b1; in_key = 56'hABCDEF12345678; shift_amount = 2'd3;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (shifted_key !== 56'h0 || out_valid !== 1'b0 || shift_err !== 1'b0)
            $display("FAIL midstream_reset: got v=%b key=%h err=%b want v=0 key=0 err=0",
                     out_valid, shifted_key, shift_err);
        else n_pass++;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (shifted_key !== 56'h0 || out_valid !== 1'b0)
            $display("FAIL post_reset_idle: got v=%b key=%h want v=0 key=0", out_valid, shifted_key);
        else n_pass++;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        test_reset();
        test_spec_vectors();
        test_hold();
        test_streaming();
        test_back_to_back();
        test_reset_midstream();
        n_total++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
